// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program memory loader that holds the CPU in reset while loading
module prog_loader #(
  parameter int Psize = 6,
  parameter int Isize = 24
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             we,
  output logic [Psize-1:0] waddr,
  output logic [Isize-1:0] wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [Psize:0]   words
);

  localparam int NB = (Isize + 7) / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0]  LAST_BYTE = BW'(NB - 1);
  localparam logic [Psize:0] DEPTH     = {1'b1, {Psize{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [Isize-1:0] sr;
  logic [Isize-1:0] sr_shift;
  logic [Psize-1:0] addr;
  logic [BW-1:0]    bcnt;
  logic             last_flag;
  logic [Psize:0]   words_inc;
  logic             final_byte;

  // New byte enters at the bottom; for a non-byte-multiple width the top bits fall off.
  if (Isize > 8) begin : g_shift
    assign sr_shift = {sr[Isize-9:0], in_data};
  end else begin : g_byte
    assign sr_shift = in_data[Isize-1:0];
  end

  assign words_inc  = words + 1'b1;
  assign final_byte = (bcnt == LAST_BYTE);
  assign waddr      = addr;
  assign wdata      = sr;

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the handshake and write strobe, which depend only on state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (final_byte)   state_next = WRITE;
          else if (in_last) state_next = ERROR;
        end
      end
      WRITE: begin
        we = 1'b1;
        if (last_flag)               state_next = DONE;
        else if (words_inc == DEPTH) state_next = ERROR;
        else                         state_next = RECV;
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and sticky status; DONE/ERROR take effect as the FSM leaves those states.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sr        <= '0;
      addr      <= '0;
      bcnt      <= '0;
      last_flag <= 1'b0;
      words     <= '0;
      busy      <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done      <= 1'b0;
            err       <= 1'b0;
            words     <= '0;
            bcnt      <= '0;
            addr      <= '0;
            last_flag <= 1'b0;
            busy      <= 1'b1;
            cpu_hold  <= 1'b1;
          end
        end
        RECV: begin
          if (in_valid) begin
            sr <= sr_shift;
            if (final_byte) begin
              bcnt <= '0;
              if (in_last) last_flag <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        WRITE: begin
          words <= words_inc;
          addr  <= addr + 1'b1;
        end
        DONE: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          done     <= 1'b1;
        end
        ERROR: begin
          busy <= 1'b0;
          err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
